// File: rtl/alu_flag_wb_stage.sv
// ALU writeback stage: 2-entry in-order result FIFO toward the register file,
// plus the architectural NZCV flag register that is committed at accept time.
module alu_flag_wb_stage #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 4,
    parameter int RD_W   = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] Result_In,
    input  logic [FLAG_W-1:0] New_Flag_In,
    input  logic              S_In,
    input  logic [RD_W-1:0]   Rd_In,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Result_Out,
    output logic [RD_W-1:0]   Rd_Out,
    output logic [FLAG_W-1:0] Flag_Out,
    output logic              Flag_Wr
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid with ready low is held by the producer, and ready never
    // depends combinationally on the other side's valid.
    logic [DATA_W-1:0] res_mem_q [2];
    logic [RD_W-1:0]   rd_mem_q  [2];

    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [FLAG_W-1:0] flag_q, flag_d;
    logic              flag_wr_q, flag_wr_d;

    logic              push;
    logic              pop;

    always_comb begin
        push       = In_Valid && in_ready_q;
        pop        = (count_q != 2'd0) && Out_Ready;
        wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d    = count_q;
        flag_d     = flag_q;
        flag_wr_d  = 1'b0;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Ready is registered from the next occupancy, so a pop while full
        // only reopens the input on the following cycle.
        in_ready_d = (count_d != 2'd2);

        // Flags commit on accept so the next ALU op sees them regardless of
        // downstream stall.
        if (push && S_In) begin
            flag_d    = New_Flag_In;
            flag_wr_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            flag_q     <= '0;
            flag_wr_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            flag_q     <= flag_d;
            flag_wr_q  <= flag_wr_d;
        end
    end

    // Storage needs no reset: the output mux forces zeros while empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            res_mem_q[wr_ptr_q] <= Result_In;
            rd_mem_q[wr_ptr_q]  <= Rd_In;
        end
    end

    assign In_Ready   = in_ready_q;
    assign Out_Valid  = (count_q != 2'd0);
    assign Result_Out = Out_Valid ? res_mem_q[rd_ptr_q] : '0;
    assign Rd_Out     = Out_Valid ? rd_mem_q[rd_ptr_q]  : '0;
    assign Flag_Out   = flag_q;
    assign Flag_Wr    = flag_wr_q;

endmodule
